// File: rtl/move_sequencer_if.sv
// -----------------------------------------------------------------------------
// move_sequencer_if
// Groups the signals between the move sequencer, the command receiver and the
// inertial/PID pair.
//   cmd         16  command word: [15:12] opcode, [11:4] heading code, [3:0] squares
//   cmd_rdy      1  command valid, level, held until acknowledged
//   heading_rdy  1  one-cycle strobe, new error/heading sample valid
//   error       12  signed heading error (actual - desired)
//   cntrIR       1  centre IR line sensor, level
//   clr_cmd_rdy  1  one-cycle acknowledge of cmd
//   send_resp    1  one-cycle pulse at move completion / unsupported-opcode ack
//   moving       1  PID enable / integrator-clear control
//   frwrd       10  unsigned forward speed to the PID
//   dsrd_hdng   12  desired heading to the inertial block
// The slave modport is the sequencer view; master is the environment view.
// -----------------------------------------------------------------------------
interface move_sequencer_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        heading_rdy;
  logic [11:0] error;
  logic        cntrIR;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        moving;
  logic [9:0]  frwrd;
  logic [11:0] dsrd_hdng;

  modport slave (
    input  cmd, cmd_rdy, heading_rdy, error, cntrIR,
    output clr_cmd_rdy, send_resp, moving, frwrd, dsrd_hdng
  );

  modport master (
    output cmd, cmd_rdy, heading_rdy, error, cntrIR,
    input  clr_cmd_rdy, send_resp, moving, frwrd, dsrd_hdng
  );
endinterface

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
// Command-level motion controller for a single move. A move command sets the
// desired heading, waits for the heading error to settle, ramps the forward
// speed up, counts IR line crossings, then ramps down and reports completion.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    move_sequencer_if.slave (command, heading, IR and PID-side signals)
// -----------------------------------------------------------------------------
module move_sequencer #(
  parameter logic [9:0]  FRWRD_INC  = 10'h018,
  parameter logic [9:0]  MAX_SPD    = 10'h300,
  parameter logic [11:0] ERR_THRESH = 12'd44
) (
  input  logic            clk,
  input  logic            rst_n,
  move_sequencer_if.slave bus
);

  localparam logic [3:0] OP_MOVE   = 4'h2;
  localparam logic [9:0] FRWRD_DEC = FRWRD_INC << 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TURN      = 2'd1,
    RAMP_UP   = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [11:0] dsrd_hdng_q, dsrd_hdng_d;
  logic [4:0]  lineCnt_q, lineCnt_d;
  logic [3:0]  squares_q, squares_d;
  logic        cntrIR_ff_q;
  logic        clrCmd, sendResp;

  logic [11:0] errAbs;
  logic        headingSettled;
  logic [10:0] rampSum;
  logic [9:0]  rampUpVal, rampDownVal;
  logic        irRise;

  // Magnitude of the heading error. 12'h800 negates to itself and, read as
  // unsigned, compares as large, so the most negative error never counts as
  // settled.
  always_comb begin
    errAbs         = bus.error[11] ? (~bus.error + 12'd1) : bus.error;
    headingSettled = (errAbs < ERR_THRESH);
  end

  // Speed ramp arithmetic. The up sum carries an extra bit so it saturates at
  // MAX_SPD instead of wrapping; the down step clamps at zero.
  always_comb begin
    rampSum     = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
    rampUpVal   = (rampSum > {1'b0, MAX_SPD}) ? MAX_SPD : rampSum[9:0];
    rampDownVal = (frwrd_q > FRWRD_DEC) ? (frwrd_q - FRWRD_DEC) : 10'd0;
    irRise      = bus.cntrIR & ~cntrIR_ff_q;
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frwrd_q     <= 10'd0;
      dsrd_hdng_q <= 12'd0;
      lineCnt_q   <= 5'd0;
      squares_q   <= 4'd0;
      cntrIR_ff_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frwrd_q     <= frwrd_d;
      dsrd_hdng_q <= dsrd_hdng_d;
      lineCnt_q   <= lineCnt_d;
      squares_q   <= squares_d;
      cntrIR_ff_q <= bus.cntrIR;
    end
  end

  // Next-state and Mealy pulse logic. Commands are only looked at in IDLE, so
  // a command arriving mid-move stays pending until the move finishes. The
  // line-count target is compared every cycle, which lets a zero-square move
  // leave RAMP_UP right away.
  always_comb begin
    state_d     = state_q;
    frwrd_d     = frwrd_q;
    dsrd_hdng_d = dsrd_hdng_q;
    lineCnt_d   = lineCnt_q;
    squares_d   = squares_q;
    clrCmd      = 1'b0;
    sendResp    = 1'b0;
    case (state_q)
      IDLE: begin
        frwrd_d = 10'd0;
        if (bus.cmd_rdy) begin
          clrCmd = 1'b1;
          if (bus.cmd[15:12] == OP_MOVE) begin
            squares_d   = bus.cmd[3:0];
            lineCnt_d   = 5'd0;
            dsrd_hdng_d = (bus.cmd[11:4] == 8'd0) ? 12'h000 : {bus.cmd[11:4], 4'hF};
            state_d     = TURN;
          end else begin
            sendResp = 1'b1;
          end
        end
      end
      TURN: begin
        frwrd_d = 10'd0;
        if (bus.heading_rdy && headingSettled) begin
          state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (bus.heading_rdy) begin
          frwrd_d = rampUpVal;
        end
        if (irRise) begin
          lineCnt_d = lineCnt_q + 5'd1;
        end
        if (lineCnt_q == {squares_q, 1'b0}) begin
          state_d = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (bus.heading_rdy) begin
          frwrd_d = rampDownVal;
        end
        if (frwrd_q == 10'd0) begin
          sendResp = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.moving      = (state_q != IDLE);
  assign bus.frwrd       = frwrd_q;
  assign bus.dsrd_hdng   = dsrd_hdng_q;
  assign bus.clr_cmd_rdy = clrCmd;
  assign bus.send_resp   = sendResp;

endmodule

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer
// Self-checking bench for move_sequencer. Inputs are driven just after the
// rising edge and outputs are checked a couple of ns later, well away from
// the next edge. Expected speeds come from the ramp rules written as plain
// integer arithmetic; expected headings from the heading-code rule.
// -----------------------------------------------------------------------------
module tb_move_sequencer;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   errors   = 0;
  int   sendCnt  = 0;
  int   clrCnt   = 0;
  int   modelSpd = 0;
  logic [11:0] turnErrs[$];

  move_sequencer_if bus();

  move_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every response and acknowledge pulse so that stray or missing
  // pulses show up as wrong totals at the end of each move.
  always @(negedge clk) begin
    if (bus.send_resp === 1'b1) sendCnt <= sendCnt + 1;
    if (bus.clr_cmd_rdy === 1'b1) clrCnt <= clrCnt + 1;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int modelUp(input int v);
    return (v + 24 > 768) ? 768 : v + 24;
  endfunction

  function automatic int modelDown(input int v);
    return (v > 48) ? v - 48 : 0;
  endfunction

  function automatic logic [11:0] modelHdng(input logic [7:0] code);
    return (code == 8'd0) ? 12'h000 : {code, 4'hF};
  endfunction

  function automatic logic [11:0] bigErr();
    int mag;
    if ($urandom_range(0, 7) == 0) return 12'h800;
    mag = $urandom_range(44, 2047);
    return ($urandom_range(0, 1) == 1) ? (12'd0 - 12'(mag)) : 12'(mag);
  endfunction

  function automatic logic [11:0] smallErr();
    int mag;
    mag = $urandom_range(0, 43);
    return ($urandom_range(0, 1) == 1) ? (12'd0 - 12'(mag)) : 12'(mag);
  endfunction

  // ---------------- helpers ----------------
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] c, input logic cr, input logic hr,
                               input logic [11:0] e, input logic ir);
    bus.cmd         = c;
    bus.cmd_rdy     = cr;
    bus.heading_rdy = hr;
    bus.error       = e;
    bus.cntrIR      = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 12'h000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic hrPulse(input logic [11:0] e);
    bus.error       = e;
    bus.heading_rdy = 1'b1;
    tick();
    bus.heading_rdy = 1'b0;
  endtask

  task automatic acceptMove(input logic [7:0] code, input logic [3:0] sq, input string tag);
    bus.cmd     = {4'h2, code, sq};
    bus.cmd_rdy = 1'b1;
    #2;
    checkOutput({tag, ".ackClr"}, bus.clr_cmd_rdy, 1);
    checkOutput({tag, ".ackSend"}, bus.send_resp, 0);
    checkOutput({tag, ".ackMoving"}, bus.moving, 0);
    tick();
    bus.cmd_rdy = 1'b0;
    #2;
    checkOutput({tag, ".clrDone"}, bus.clr_cmd_rdy, 0);
    checkOutput({tag, ".moving"}, bus.moving, 1);
    checkOutput({tag, ".dsrd"}, bus.dsrd_hdng, modelHdng(code));
    checkOutput({tag, ".frwrd0"}, bus.frwrd, 0);
  endtask

  task automatic finishTurn(input int toggles, input string tag);
    for (int t = 0; t < toggles; t++) begin
      bus.cntrIR = 1'b1;
      tick();
      bus.cntrIR = 1'b0;
      tick();
    end
    foreach (turnErrs[i]) begin
      repeat ($urandom_range(0, 2)) tick();
      hrPulse(turnErrs[i]);
      #2;
      checkOutput({tag, ".turnFrwrd"}, bus.frwrd, 0);
      checkOutput({tag, ".turnMoving"}, bus.moving, 1);
    end
    modelSpd = 0;
  endtask

  task automatic rampBeats(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      hrPulse(12'($urandom));
      modelSpd = modelUp(modelSpd);
      #2;
      checkOutput({tag, ".up"}, bus.frwrd, 32'(modelSpd));
    end
  endtask

  task automatic crossings(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      bus.cntrIR = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      bus.cntrIR = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      if (c < n - 1) rampBeats(1, {tag, ".xing"});
    end
  endtask

  task automatic rampDownAll(input string tag);
    bit found;
    int guard;
    #2;
    checkOutput({tag, ".hold"}, bus.frwrd, 32'(modelSpd));
    guard = 0;
    while (modelSpd != 0 && guard < 40) begin
      repeat ($urandom_range(0, 2)) tick();
      hrPulse(12'($urandom));
      modelSpd = modelDown(modelSpd);
      guard++;
      #2;
      checkOutput({tag, ".down"}, bus.frwrd, 32'(modelSpd));
    end
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        tick();
        #2;
      end
      if (bus.send_resp === 1'b1) begin
        found = 1'b1;
        checkOutput({tag, ".clrAtSend"}, bus.clr_cmd_rdy, 0);
        break;
      end
    end
    checkOutput({tag, ".sendSeen"}, found, 1);
  endtask

  task automatic runMove(input logic [7:0] code, input logic [3:0] sq, input int up,
                         input int toggles, input bit longHold, input bit pendEn,
                         input logic [15:0] pendCmd, input string tag);
    int s0, c0;
    s0 = sendCnt;
    c0 = clrCnt;
    acceptMove(code, sq, tag);
    finishTurn(toggles, tag);
    rampBeats(up, tag);
    if (pendEn) begin
      bus.cmd     = pendCmd;
      bus.cmd_rdy = 1'b1;
    end
    if (longHold) begin
      bus.cntrIR = 1'b1;
      repeat (50) tick();
      bus.cntrIR = 1'b0;
      tick();
      rampBeats(1, {tag, ".afterHold"});
      crossings(2 * int'(sq) - 1, tag);
    end else begin
      crossings(2 * int'(sq), tag);
    end
    rampDownAll(tag);
    checkOutput({tag, ".dsrdKept"}, bus.dsrd_hdng, modelHdng(code));
    tick();
    if (pendEn) begin
      #2;
      checkOutput({tag, ".pendClr"}, bus.clr_cmd_rdy, 1);
      checkOutput({tag, ".pendSend"}, bus.send_resp, 0);
      tick();
      bus.cmd_rdy = 1'b0;
      #2;
      checkOutput({tag, ".pendMoving"}, bus.moving, 1);
      checkOutput({tag, ".pendDsrd"}, bus.dsrd_hdng, modelHdng(pendCmd[11:4]));
    end else begin
      #2;
      checkOutput({tag, ".idleMoving"}, bus.moving, 0);
      checkOutput({tag, ".idleSend"}, bus.send_resp, 0);
      checkOutput({tag, ".idleFrwrd"}, bus.frwrd, 0);
    end
    tick();
    checkOutput({tag, ".sendTotal"}, 32'(sendCnt - s0), 1);
    checkOutput({tag, ".clrTotal"}, 32'(clrCnt - c0), pendEn ? 2 : 1);
  endtask

  // ---------------- directed/randomized sequence ----------------
  initial begin
    logic [3:0]  op;
    logic [15:0] cmdV;
    logic [7:0]  code;
    int          s0;
    int          pulses;

    applyStimulus(16'h0000, 1'b0, 1'b0, 12'h000, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst.frwrd", bus.frwrd, 0);
    checkOutput("rst.moving", bus.moving, 0);
    checkOutput("rst.dsrd", bus.dsrd_hdng, 0);
    checkOutput("rst.clr", bus.clr_cmd_rdy, 0);
    checkOutput("rst.send", bus.send_resp, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    #2;
    checkOutput("rst.idleMoving", bus.moving, 0);

    // Unsupported opcodes: acknowledge and respond together, stay idle.
    for (int i = 0; i < 3; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h2) op = 4'hE;
      cmdV = (i == 0) ? 16'h5000 : {op, 12'($urandom)};
      tick();
      bus.cmd     = cmdV;
      bus.cmd_rdy = 1'b1;
      #2;
      checkOutput("badop.clr", bus.clr_cmd_rdy, 1);
      checkOutput("badop.send", bus.send_resp, 1);
      checkOutput("badop.moving", bus.moving, 0);
      tick();
      bus.cmd_rdy = 1'b0;
      #2;
      checkOutput("badop.clrOff", bus.clr_cmd_rdy, 0);
      checkOutput("badop.sendOff", bus.send_resp, 0);
      checkOutput("badop.movingOff", bus.moving, 0);
      checkOutput("badop.dsrd", bus.dsrd_hdng, 0);
    end
    tick();

    // Heading encoding: 0x3F, zero code, then random codes.
    for (int i = 0; i < 5; i++) begin
      code = (i == 0) ? 8'h3F : (i == 1) ? 8'h00 : 8'($urandom);
      acceptMove(code, 4'd1, "hdng");
      doReset();
    end

    // Full move from the plan: heading 0, two squares.
    turnErrs.delete();
    turnErrs.push_back(12'h100);
    turnErrs.push_back(12'h100);
    turnErrs.push_back(12'h100);
    turnErrs.push_back(12'h010);
    runMove(8'h00, 4'd2, 34, 0, 1'b0, 1'b0, 16'h0000, "full");

    // Threshold boundaries: 44, -44 and 0x800 are large, -43 settles.
    turnErrs.delete();
    turnErrs.push_back(12'd44);
    turnErrs.push_back(12'hFD4);
    turnErrs.push_back(12'h800);
    turnErrs.push_back(12'hFD5);
    runMove(8'h12, 4'd1, 3, 0, 1'b0, 1'b0, 16'h0000, "bound");

    // Edge filtering: toggles in TURN ignored, a long high counts once.
    turnErrs.delete();
    turnErrs.push_back(bigErr());
    turnErrs.push_back(12'd43);
    runMove(8'h7C, 4'd1, 5, 3, 1'b1, 1'b0, 16'h0000, "edge");

    // Command arriving mid-move waits until the move completes.
    turnErrs.delete();
    turnErrs.push_back(smallErr());
    runMove(8'h21, 4'd2, 6, 0, 1'b0, 1'b1, 16'h2A51, "busy");
    doReset();

    // Randomized moves.
    for (int i = 0; i < 3; i++) begin
      turnErrs.delete();
      repeat ($urandom_range(0, 3)) turnErrs.push_back(bigErr());
      turnErrs.push_back(smallErr());
      runMove(8'($urandom), 4'($urandom_range(1, 3)), $urandom_range(1, 40),
              0, 1'b0, 1'b0, 16'h0000, "rand");
    end

    // Zero squares: straight through to ramp-down and a single response.
    acceptMove(8'($urandom), 4'd0, "sq0");
    turnErrs.delete();
    turnErrs.push_back(smallErr());
    finishTurn(0, "sq0");
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      #2;
      if (bus.send_resp === 1'b1) pulses++;
      checkOutput("sq0.frwrd", bus.frwrd, 0);
    end
    checkOutput("sq0.sendPulses", 32'(pulses), 1);
    checkOutput("sq0.moving", bus.moving, 0);

    // Reset in the middle of RAMP_UP at frwrd 0x120.
    tick();
    acceptMove(8'h40, 4'd3, "mid");
    turnErrs.delete();
    turnErrs.push_back(smallErr());
    finishTurn(0, "mid");
    rampBeats(12, "mid");
    checkOutput("mid.frwrd120", bus.frwrd, 32'h120);
    s0 = sendCnt;
    rst_n = 1'b0;
    #1;
    checkOutput("mid.rstFrwrd", bus.frwrd, 0);
    checkOutput("mid.rstMoving", bus.moving, 0);
    checkOutput("mid.rstDsrd", bus.dsrd_hdng, 0);
    checkOutput("mid.rstSend", bus.send_resp, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    #2;
    checkOutput("mid.noSend", 32'(sendCnt - s0), 0);
    checkOutput("mid.idleMoving", bus.moving, 0);
    checkOutput("mid.idleFrwrd", bus.frwrd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Command-level motion controller that sequences the PID steering datapath for a single move.
- Accepts a 16-bit move command and drives the desired heading.
- Drives the PID enable (`moving`) and the forward-speed ramp (`frwrd`).
- Counts IR line crossings to decide when the move is complete.
- Sits between the command receiver (`cmd`/`cmd_rdy`) and the inertial/PID pair; reports completion with `send_resp`.

Parameters:
- FRWRD_INC, 10'h018, frwrd step per heading_rdy during ramp-up (ramp-down step is 2*FRWRD_INC).
- MAX_SPD, 10'h300, frwrd saturation ceiling.
- ERR_THRESH, 12'd44, |error| below which the turn is considered complete.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd  in  16  command word: [15:12] opcode, [11:4] heading code, [3:0] squares
- cmd_rdy  in  1  command valid, level, held until cleared
- heading_rdy  in  1  one-cycle strobe; new error/heading sample valid
- error  in  12  signed heading error (actual - desired), same encoding as the PID error input
- cntrIR  in  1  centre IR line sensor, level
- clr_cmd_rdy  out  1  one-cycle pulse acknowledging cmd
- send_resp  out  1  one-cycle pulse at move completion or unsupported-opcode ack
- moving  out  1  PID enable / integrator-clear control
- frwrd  out  10  unsigned forward speed to PID
- dsrd_hdng  out  12  desired heading to inertial block

Behaviour:
- Single clock domain; all flops reset asynchronously on rst_n low.
- Reset values: state=IDLE, frwrd=0, dsrd_hdng=0, line count=0, cntrIR_ff=0.
- Reset values (Mealy outputs): moving=0, clr_cmd_rdy=0, send_resp=0.
- States: IDLE, TURN, RAMP_UP, RAMP_DOWN.
- moving = 1 in TURN, RAMP_UP and RAMP_DOWN; moving = 0 in IDLE. Decoded from the state register.
- IDLE:
  - frwrd is forced to 0.
  - On cmd_rdy=1 with opcode 4'h2: pulse clr_cmd_rdy this cycle, register squares, and clear the line count.
  - Also register dsrd_hdng = {cmd[11:4],4'hF}, or 12'h000 when cmd[11:4]==0. Next state is TURN.
  - On cmd_rdy=1 with any other opcode: pulse clr_cmd_rdy and send_resp in the same cycle; stay in IDLE.
- TURN:
  - frwrd held at 0.
  - On heading_rdy=1 with signed |error| < ERR_THRESH, go to RAMP_UP.
  - Absolute value is computed in 12 bits; error=12'h800 is treated as large.
- RAMP_UP:
  - On each heading_rdy, frwrd <= min(frwrd+FRWRD_INC, MAX_SPD). The sum is computed in 11 bits and never wraps.
  - When line count == {squares,1'b0}, go to RAMP_DOWN. This compare is evaluated every cycle, not only on heading_rdy.
- Line counting:
  - Line count is 5 bits and increments on each cntrIR rising edge (cntrIR & ~cntrIR_ff), only in RAMP_UP.
  - Edges seen in other states are ignored.
  - cntrIR_ff is updated every cycle in all states.
- RAMP_DOWN:
  - On each heading_rdy, frwrd <= (frwrd > 2*FRWRD_INC) ? frwrd-2*FRWRD_INC : 0. Never underflows.
  - When frwrd==0: pulse send_resp, go to IDLE.
- squares=0: RAMP_UP sees count==0 immediately and goes to RAMP_DOWN one cycle after entry with frwrd at most one increment. This is legal behaviour.
- cmd_rdy while not IDLE is ignored: no clr_cmd_rdy, command left pending, and it is accepted on return to IDLE.
- A heading_rdy and a state transition in the same cycle: the ramp update of the current state applies, then the state changes.
- Reset mid-move: all state returns to reset values immediately (moving drops asynchronously via the state register); no send_resp is issued.
- dsrd_hdng changes only when a move command is accepted.

Test Plan:
- Reset, then idle: rst_n low mid-RAMP_UP with frwrd=0x120 -> frwrd=0, moving=0, state IDLE asynchronously; no send_resp after release.
- Unsupported opcode: cmd=16'h5000, cmd_rdy=1 -> clr_cmd_rdy and send_resp pulse together for exactly 1 cycle; moving stays 0.
- Full move:
  - Stimulus: cmd=16'h2002 (heading 0, 2 squares); error=12'h100 for 3 heading_rdy, then 12'h010.
  - Required: dsrd_hdng=0; stays in TURN until |error|<44, then ramp-up.
  - Required: frwrd reaches 0x300 after 32 heading_rdy and holds.
  - After 4 cntrIR pulses: ramp-down in steps of 0x030, reaching 0 after 16 heading_rdy, then a single send_resp.
- Heading encoding: cmd=16'h23F1 -> dsrd_hdng=12'h3FF; cmd=16'h2001 -> dsrd_hdng=12'h000.
- Edge filtering: hold cntrIR high for 50 cycles during RAMP_UP -> count increments by 1 only. cntrIR toggling in TURN -> count stays 0.
- Busy command: new cmd_rdy asserted during RAMP_UP -> no clr_cmd_rdy until the cycle after send_resp/IDLE entry, then it is accepted.
